// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the timer sequencer: command op codes and FSM states.
package timer_sequencer_pkg;

  localparam logic [1:0] OP_LOAD_PERIOD  = 2'd0;
  localparam logic [1:0] OP_START        = 2'd1;
  localparam logic [1:0] OP_STOP         = 2'd2;
  localparam logic [1:0] OP_SET_PRESCALE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into count ticks: one tick every (prescale+1) enabled cycles.
module tick_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [PRE_W-1:0] prescale_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  // A clear (start/stop) restarts the prescale window and suppresses the tick.
  assign tick_o = enable_i && !clear_i && (pre_cnt_q >= prescale_i);

  // Next prescale count: wrap on tick, otherwise advance while enabled.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear_i) begin
      pre_cnt_d = '0;
    end else if (enable_i) begin
      if (tick_o) pre_cnt_d = '0;
      else        pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  // Prescale count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/timer_sequencer.sv
// Command-driven timer: programmable period and prescale, one-shot or periodic,
// with expiry pulse, sticky irq and overrun flags.
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expire,
  output logic             irq,
  output logic             overrun,
  output logic             cmd_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_pend_q, period_pend_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             mode_q, mode_d;
  logic             expire_q, expire_d;
  logic             irq_q, irq_d;
  logic             overrun_q, overrun_d;
  logic             cmd_err_q, cmd_err_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic accept, start_ok, stop_run, tick;

  assign accept   = cmd_valid && cmd_ready_q;
  assign start_ok = accept && (cmd_op == OP_START) && (period_pend_q != '0);
  assign stop_run = accept && (cmd_op == OP_STOP) && (state_q == ST_RUN);

  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (state_q == ST_RUN),
    .clear_i    (start_ok || stop_run),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  // Command decode, counter advance and flag updates; commands override a same-cycle tick.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    period_pend_d = period_pend_q;
    period_act_d  = period_act_q;
    prescale_d    = prescale_q;
    mode_d        = mode_q;
    expire_d      = 1'b0;
    cmd_err_d     = 1'b0;
    cmd_ready_d   = !accept;

    if (accept) begin
      case (cmd_op)
        OP_LOAD_PERIOD:  period_pend_d = cmd_data;
        OP_SET_PRESCALE: prescale_d    = cmd_data[PRE_W-1:0];
        OP_START: begin
          if (period_pend_q == '0) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d      = ST_RUN;
            count_d      = '0;
            period_act_d = period_pend_q;
            mode_d       = cmd_mode;
          end
        end
        default: begin
          if (state_q == ST_RUN) state_d = ST_IDLE;
        end
      endcase
    end

    if (!start_ok && !stop_run && tick) begin
      if (count_q == period_act_q - WIDTH'(1)) begin
        count_d  = '0;
        expire_d = 1'b1;
        if (mode_q) period_act_d = period_pend_q;
        else        state_d      = ST_DONE;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end

    // Set beats clear on irq; overrun records an expiry that found irq still pending.
    irq_d     = expire_d ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    overrun_d = (expire_d && irq_q && !irq_clr) ? 1'b1 : (irq_clr ? 1'b0 : overrun_q);
  end

  // State and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      period_pend_q <= '0;
      period_act_q  <= '0;
      prescale_q    <= '0;
      mode_q        <= 1'b0;
      expire_q      <= 1'b0;
      irq_q         <= 1'b0;
      overrun_q     <= 1'b0;
      cmd_err_q     <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      period_pend_q <= period_pend_d;
      period_act_q  <= period_act_d;
      prescale_q    <= prescale_d;
      mode_q        <= mode_d;
      expire_q      <= expire_d;
      irq_q         <= irq_d;
      overrun_q     <= overrun_d;
      cmd_err_q     <= cmd_err_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign count     = count_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign expire    = expire_q;
  assign irq       = irq_q;
  assign overrun   = overrun_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: scenario tasks plus an expiry scoreboard keyed on cycle number.
module tb_timer_sequencer;

  localparam int WIDTH = 32;
  localparam int PRE_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic             cmd_mode = 1'b0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             irq_clr = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy, done, expire, irq, overrun, cmd_err;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int exp_q[$];

  timer_sequencer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_data(cmd_data), .irq_clr(irq_clr),
    .count(count), .busy(busy), .done(done), .expire(expire), .irq(irq),
    .overrun(overrun), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed expire pulse must match the next expected edge number.
  always @(negedge clk) begin
    int e;
    if (reset && expire) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_expire at cycle %0d (no expiry expected)", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e) begin
          fails++;
          $display("FAIL expire_cycle actual %0d expected %0d", cyc, e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    irq_clr = 1'b0;
    step(2);
    exp_q.delete();
    reset = 1'b1;
  endtask

  // Issue one command; returns #1 after the accepting edge with that edge's number.
  task automatic send(input logic [1:0] op, input logic mode, input logic [WIDTH-1:0] data,
                      output int acc);
    int waited = 0;
    while (!cmd_ready && waited < 10) begin
      step();
      waited++;
    end
    tests_run++;
    if (!cmd_ready) begin
      fails++;
      $display("FAIL cmd_ready_timeout actual %0b expected 1", cmd_ready);
    end
    cmd_op = op; cmd_mode = mode; cmd_data = data; cmd_valid = 1'b1;
    step();
    acc = cyc;
    cmd_valid = 1'b0;
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL cmd_ready_drop actual %0b expected 0", cmd_ready);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending_expires actual %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    send(2'd0, 1'b0, 32'd5, n);
    send(2'd1, 1'b1, 32'd0, n);
    step(2);
    tests_run++;
    if (count !== 32'd2) begin
      fails++;
      $display("FAIL reset_precount actual %0d expected 2", count);
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      tests_run++;
      if ({count, busy, done, expire, irq, overrun, cmd_err, cmd_ready} !== {32'd0, 7'b0000001}) begin
        fails++;
        $display("FAIL reset_outputs actual cnt=%0d b=%0b d=%0b e=%0b i=%0b o=%0b er=%0b rdy=%0b expected 0s rdy=1",
                 count, busy, done, expire, irq, overrun, cmd_err, cmd_ready);
      end
    end
    reset = 1'b1;
    step(12);
    tests_run++;
    if ({count, busy, irq} !== {32'd0, 2'b00}) begin
      fails++;
      $display("FAIL reset_after actual cnt=%0d busy=%0b irq=%0b expected 0 0 0", count, busy, irq);
    end
  endtask

  task automatic test_periodic();
    int n;
    logic [WIDTH-1:0] exp_cnt [4];
    exp_cnt[0] = 32'd1; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd3; exp_cnt[3] = 32'd0;
    do_reset();
    send(2'd3, 1'b0, 32'd0, n);
    send(2'd0, 1'b0, 32'd4, n);
    send(2'd1, 1'b1, 32'd0, n);
    exp_q.push_back(n + 4); exp_q.push_back(n + 8); exp_q.push_back(n + 12);
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (count !== exp_cnt[k] || busy !== 1'b1) begin
        fails++;
        $display("FAIL periodic_count[%0d] actual %0d busy=%0b expected %0d busy=1", k, count, busy, exp_cnt[k]);
      end
    end
    drain("periodic");
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL periodic_busy actual %0b expected 1", busy);
    end
    do_reset();
  endtask

  task automatic test_oneshot();
    int n;
    do_reset();
    send(2'd3, 1'b0, 32'd2, n);
    send(2'd0, 1'b0, 32'd3, n);
    send(2'd1, 1'b0, 32'd0, n);
    exp_q.push_back(n + 9);
    for (int k = 1; k <= 2; k++) begin
      step(3);
      tests_run++;
      if (count !== WIDTH'(k) || busy !== 1'b1) begin
        fails++;
        $display("FAIL oneshot_step%0d actual %0d busy=%0b expected %0d busy=1", k, count, busy, k);
      end
    end
    step(3);
    tests_run++;
    if ({count, done, busy} !== {32'd0, 2'b10}) begin
      fails++;
      $display("FAIL oneshot_end actual cnt=%0d done=%0b busy=%0b expected 0 1 0", count, done, busy);
    end
    step(10);
    drain("oneshot");
    tests_run++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL oneshot_done_hold actual %0b expected 1", done);
    end
  endtask

  task automatic test_error();
    int n;
    do_reset();
    send(2'd1, 1'b1, 32'd0, n);
    tests_run++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL error_pulse actual err=%0b busy=%0b expected 1 0", cmd_err, busy);
    end
    step();
    tests_run++;
    if ({cmd_err, busy, done, cmd_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL error_after actual err=%0b busy=%0b done=%0b rdy=%0b expected 0 0 0 1",
               cmd_err, busy, done, cmd_ready);
    end
  endtask

  task automatic test_flags();
    int n;
    do_reset();
    send(2'd3, 1'b0, 32'd0, n);
    send(2'd0, 1'b0, 32'd2, n);
    send(2'd1, 1'b1, 32'd0, n);
    exp_q.push_back(n + 2); exp_q.push_back(n + 4);
    exp_q.push_back(n + 6); exp_q.push_back(n + 8);
    step(2);
    tests_run++;
    if ({irq, overrun} !== 2'b10) begin
      fails++;
      $display("FAIL flags_first actual irq=%0b ovr=%0b expected 1 0", irq, overrun);
    end
    step(2);
    tests_run++;
    if ({irq, overrun} !== 2'b11) begin
      fails++;
      $display("FAIL flags_overrun actual irq=%0b ovr=%0b expected 1 1", irq, overrun);
    end
    step();
    irq_clr = 1'b1;
    step();
    tests_run++;
    if ({irq, overrun, expire} !== 3'b101) begin
      fails++;
      $display("FAIL flags_clr_vs_set actual irq=%0b ovr=%0b exp=%0b expected 1 0 1", irq, overrun, expire);
    end
    step();
    irq_clr = 1'b0;
    tests_run++;
    if ({irq, overrun} !== 2'b00) begin
      fails++;
      $display("FAIL flags_cleared actual irq=%0b ovr=%0b expected 0 0", irq, overrun);
    end
    step();
    tests_run++;
    if ({irq, overrun} !== 2'b10) begin
      fails++;
      $display("FAIL flags_reset_then_set actual irq=%0b ovr=%0b expected 1 0", irq, overrun);
    end
    send(2'd2, 1'b0, 32'd0, n);
    tests_run++;
    if (busy !== 1'b0 || count !== 32'd0) begin
      fails++;
      $display("FAIL flags_stop actual busy=%0b cnt=%0d expected 0 0", busy, count);
    end
    step(4);
    drain("flags");
  endtask

  task automatic test_back_to_back();
    int n, m;
    do_reset();
    send(2'd3, 1'b0, 32'd0, n);
    send(2'd0, 1'b0, 32'd4, n);
    send(2'd1, 1'b1, 32'd0, n);
    exp_q.push_back(n + 4); exp_q.push_back(n + 6); exp_q.push_back(n + 8);
    send(2'd0, 1'b0, 32'd2, m);
    tests_run++;
    if (m - n !== 2) begin
      fails++;
      $display("FAIL b2b_accept_gap actual %0d expected 2", m - n);
    end
    step();
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready_return actual %0b expected 1", cmd_ready);
    end
    drain("pending");
    do_reset();
  endtask

  initial begin
    do_reset();
    tests_run++;
    if ({count, busy, done, expire, irq, overrun, cmd_err, cmd_ready} !== {32'd0, 7'b0000001}) begin
      fails++;
      $display("FAIL initial_reset actual cnt=%0d rdy=%0b expected 0 1", count, cmd_ready);
    end
    test_reset();
    test_periodic();
    test_oneshot();
    test_error();
    test_flags();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
